// File: rtl/div4_seq_ctrl.sv
// div4_seq_ctrl: multi-cycle restoring divider controller for the 4-bit ALU.
// Accepts one request at a time (start/busy/done) and produces one quotient
// bit per clock. A divisor of zero completes in one edge with Error=1.
// Optional build macro DIV_FAST_POW2_EN: power-of-two divisors bypass the
// iterative path and complete in one edge with identical results.
// state_dbg exposes the FSM state for checkers.
module div4_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Error,
    output logic [1:0]       state_dbg
);

    // Handshake: start is level-sampled only in IDLE; while busy=1 (CALC or
    // DONE) start is ignored and not queued. done is a one-cycle pulse and
    // Quotient/Remainder/Error are valid in that cycle and hold afterwards.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dq_q, dq_d;     // dividend shift reg, fills with quotient bits
    logic [WIDTH-1:0] div_q, div_d;   // latched divisor
    logic [WIDTH-1:0] r_q, r_d;       // kept remainder, always < divisor
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The trial partial remainder is WIDTH+1 bits so the compare never
    // overflows; after a restoring step it is below the divisor again.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] dq_next;
    logic [WIDTH:0]   r_next;

`ifdef DIV_FAST_POW2_EN
    logic             is_pow2;
    logic [CNT_W-1:0] shift_k;

    // Detect a single-bit divisor and find which bit is set.
    always_comb begin
        is_pow2 = (B != '0) && ((B & (B - 1'b1)) == '0);
        shift_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (B[i]) shift_k = CNT_W'(i);
        end
    end
`endif

    // Next-state, datapath step and registered-output computation.
    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        div_d   = div_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;

        trial   = {r_q, dq_q[WIDTH-1]};
        diff    = trial - {1'b0, div_q};
        qbit    = (trial >= {1'b0, div_q});
        dq_next = {dq_q[WIDTH-2:0], qbit};
        r_next  = qbit ? diff : trial;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        quot_d  = '0;
                        rem_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`ifdef DIV_FAST_POW2_EN
                    else if (is_pow2) begin
                        quot_d  = A >> shift_k;
                        rem_d   = A & (B - 1'b1);
                        err_d   = 1'b0;
                        state_d = DONE;
                    end
`endif
                    else begin
                        dq_d    = A;
                        div_d   = B;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dq_d  = dq_next;
                r_d   = r_next[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quot_d  = dq_next;
                    rem_d   = r_next[WIDTH-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dq_q    <= '0;
            div_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            div_q   <= div_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign Error     = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_div4_seq_ctrl.sv
// tb_div4_seq_ctrl: directed bench for div4_seq_ctrl with hand-computed
// expectations and an exhaustive sweep against a behavioural divide model.
module tb_div4_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       error;
    logic [1:0] state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    div4_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (a_in),
        .B         (b_in),
        .busy      (busy),
        .done      (done),
        .Quotient  (quotient),
        .Remainder (remainder),
        .Error     (error),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Edges from the accepting edge up to and including the one raising done.
    function automatic int exp_lat(input int b);
        if (b == 0) return 1;
`ifdef DIV_FAST_POW2_EN
        if ((b & (b - 1)) == 0) return 1;
`endif
        return 5;
    endfunction

    // One complete request: checks latency, busy during the wait, results,
    // and the return to IDLE with results held.
    task automatic run_div(input string tag, input int a, input int b,
                           input int eq, input int er, input int ee);
        int   n;
        logic busy_bad;
        a_in  = 4'(a);
        b_in  = 4'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            step();
            n++;
        end
        check({tag, " latency"}, n, exp_lat(b));
        check({tag, " busy_wait"}, busy_bad, 0);
        check({tag, " busy_at_done"}, busy, 1);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " error"}, error, ee);
        step();
        check({tag, " done_pulse"}, done, 0);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " hold_q"}, quotient, eq);
    endtask

    initial begin
        int dcount;
        int cap_q;
        int cap_r;
        int t4_b;
        int t4_q;
        int t4_r;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        check("rst error", error, 0);
        check("rst state", state_dbg, 0);
        rst = 1'b0;
        step();

        // 1: basic 13/3
        run_div("t1_13_3", 13, 3, 4, 1, 0);
        step();
        check("t1 hold_r", remainder, 1);

        // 2: divide by zero, then a clean request clears Error
        run_div("t2_7_0", 7, 0, 0, 0, 1);
        run_div("t2_6_2", 6, 2, 3, 0, 0);

        // 3: power-of-two divisors
        run_div("t3_15_1", 15, 1, 15, 0, 0);
        run_div("t3_11_4", 11, 4, 2, 3, 0);

        // 4: start while busy is ignored
`ifdef DIV_FAST_POW2_EN
        t4_b = 3; t4_q = 3; t4_r = 0;
`else
        t4_b = 2; t4_q = 4; t4_r = 1;
`endif
        a_in  = 4'd9;
        b_in  = 4'(t4_b);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t4 busy_before_2nd", busy, 1);
        a_in  = 4'd15;
        b_in  = 4'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        dcount = 0;
        cap_q  = -1;
        cap_r  = -1;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                dcount++;
                cap_q = int'(quotient);
                cap_r = int'(remainder);
            end
            step();
        end
        check("t4 done_count", dcount, 1);
        check("t4 quotient", cap_q, t4_q);
        check("t4 remainder", cap_r, t4_r);

        // 5: reset mid-operation
        a_in  = 4'd14;
        b_in  = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t5 busy", busy, 0);
        check("t5 done", done, 0);
        check("t5 quotient", quotient, 0);
        check("t5 remainder", remainder, 0);
        check("t5 error", error, 0);
        check("t5 state", state_dbg, 0);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) dcount++;
        end
        check("t5 no_done", dcount, 0);
        run_div("t5_6_6", 6, 6, 1, 0, 0);

        // Level-sampled start: held high, re-accepted once back in IDLE
        a_in  = 4'd8;
        b_in  = 4'd0;
        start = 1'b1;
        step();
        check("lvl first_done", done, 1);
        step();
        check("lvl idle_gap_done", done, 0);
        check("lvl idle_gap_busy", busy, 0);
        step();
        check("lvl second_done", done, 1);
        check("lvl error", error, 1);
        start = 1'b0;
        step();

        // 6: A < B, then exhaustive sweep against the model
        run_div("t6_3_9", 3, 9, 0, 3, 0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) run_div($sformatf("sw_%0d_%0d", a, b), a, b, 0, 0, 1);
                else        run_div($sformatf("sw_%0d_%0d", a, b), a, b, a / b, a % b, 0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
